// File: rtl/fpga_pll_lock_seq_if.sv
// Signal bundle between the PLL lock supervisor and its environment:
// the clocking primitive's lock/reset pair plus the per-domain resets and status.
interface fpga_pll_lock_seq_if #(
    parameter int N_DOM = 2
);
    logic             pll_lock;
    logic             soft_rst;
    logic             pll_rst;
    logic [N_DOM-1:0] dom_rst;
    logic             ready;
    logic             fault;
    logic [3:0]       retry_cnt;
    logic [7:0]       loss_cnt;
    logic [2:0]       state_dbg;

    // No handshake: every signal is a level, valid on every cycle of clk_ext.
    modport master (
        input  pll_lock, soft_rst,
        output pll_rst, dom_rst, ready, fault, retry_cnt, loss_cnt, state_dbg
    );

    modport slave (
        output pll_lock, soft_rst,
        input  pll_rst, dom_rst, ready, fault, retry_cnt, loss_cnt, state_dbg
    );
endinterface

// File: rtl/fpga_pll_lock_seq.sv
// PLL/MMCM lock supervisor: pulses the PLL reset, qualifies lock, retries on
// timeout and releases N_DOM domain resets in staggered order.
module fpga_pll_lock_seq #(
    parameter int N_DOM        = 2,
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STAGGER      = 8,
    parameter int MAX_RETRY    = 3
) (
    input logic                 clk_ext,
    input logic                 rst,
    fpga_pll_lock_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam int REL_END = (N_DOM - 1) * STAGGER + 1;
    localparam int RST_W   = $clog2(PLL_RST_CYC + 1);
    localparam int STAB_W  = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int REL_W   = $clog2(REL_END + 1);

    localparam logic [RST_W-1:0]  RST_LAST    = RST_W'(PLL_RST_CYC - 1);
    localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(LOCK_STABLE);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [REL_W-1:0]  REL_LAST    = REL_W'(REL_END);
    localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRY);

    state_t state_q, state_d;

    logic              lock_m, lock_s;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_d;
    logic [STAB_W-1:0] stab_cnt, stab_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
    logic [REL_W-1:0]  rel_cnt, rel_cnt_d;

    logic             pll_rst_q;
    logic [N_DOM-1:0] dom_rst_q, dom_rst_d;
    logic             ready_q;
    logic             fault_q, fault_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             lost;
    logic             stay;

    // pll_lock is asynchronous to clk_ext; only lock_s is used downstream.
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            rst_cnt   <= '0;
            stab_cnt  <= '0;
            tmo_cnt   <= '0;
            rel_cnt   <= '0;
            pll_rst_q <= 1'b1;
            dom_rst_q <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            retry_q   <= '0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt   <= rst_cnt_d;
            stab_cnt  <= stab_cnt_d;
            tmo_cnt   <= tmo_cnt_d;
            rel_cnt   <= rel_cnt_d;
            pll_rst_q <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
            dom_rst_q <= dom_rst_d;
            ready_q   <= (state_d == S_RUN);
            fault_q   <= fault_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        fault_d = fault_q;
        lost    = 1'b0;

        if (bus.soft_rst) begin
            state_d = S_PLL_RST;
            retry_d = '0;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (rst_cnt == RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // Reaching stability wins over a timeout on the same cycle.
                    if (stab_cnt == STAB_LAST) begin
                        state_d = S_RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (retry_q < RETRY_LIMIT) begin
                            retry_d = retry_q + 4'd1;
                            state_d = S_PLL_RST;
                        end else begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) begin
                        lost = 1'b1;
                    end else if (rel_cnt == REL_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) lost = 1'b1;
                end
                S_FAULT: ;
                default: state_d = S_PLL_RST;
            endcase
        end

        if (lost) begin
            state_d = S_PLL_RST;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end

        // Counters run only while the state is held; any entry or soft restart clears them.
        stay       = (state_d == state_q) && !bus.soft_rst;
        rst_cnt_d  = (stay && state_q == S_PLL_RST) ? rst_cnt + 1'b1 : '0;
        stab_cnt_d = (stay && state_q == S_WAIT_LOCK && lock_s) ? stab_cnt + 1'b1 : '0;
        tmo_cnt_d  = (stay && state_q == S_WAIT_LOCK) ? tmo_cnt + 1'b1 : '0;
        rel_cnt_d  = (stay && state_q == S_RELEASE) ? rel_cnt + 1'b1 : '0;

        dom_rst_d = '1;
        if (state_d == S_RUN) begin
            dom_rst_d = '0;
        end else if (stay && state_q == S_RELEASE) begin
            for (int i = 0; i < N_DOM; i++) begin
                dom_rst_d[i] = dom_rst_q[i] && (32'(rel_cnt) != 32'(i * STAGGER));
            end
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.dom_rst   = dom_rst_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;
    assign bus.state_dbg = state_q;
endmodule

// File: doc/fpga_pll_lock_seq.md
Name: fpga_pll_lock_seq

Overview:
- Parametrised PLL/MMCM lock supervisor and multi-domain reset sequencer.
- Successor to the single-output lock-to-reset pipe: it drives the PLL reset, qualifies lock, and retries on lock timeout.
- Releases N_DOM domain resets in staggered order, tears all of them down on lock loss, and latches a fault after repeated failures.
- Sits beside the clocking primitive, in the free-running reference clock domain; each consumer synchronises its own dom_rst bit locally.

Parameters:
- N_DOM, 2, number of downstream reset domains (1..16).
- PLL_RST_CYC, 16, cycles pll_rst is held high per attempt (>=1).
- LOCK_STABLE, 1024, consecutive synchronised-lock cycles required before release (>=1).
- LOCK_TIMEOUT, 65536, maximum cycles spent in WAIT_LOCK per attempt (>LOCK_STABLE).
- STAGGER, 8, cycles between successive domain releases (>=1).
- MAX_RETRY, 3, timeout retries before FAULT (0..15).

Ports:
- clk_ext  in  1  free-running reference clock; all logic runs on it.
- rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  raw LOCKED from the MMCM/PLL, asynchronous.
- soft_rst  in  1  synchronous, single-cycle request to restart the full sequence.
- pll_rst  out  1  reset to the MMCM/PLL, active-high.
- dom_rst  out  N_DOM  per-domain reset, active-high; bit i releases i-th.
- ready  out  1  high when all domains are released and lock is held.
- fault  out  1  sticky; set when a timeout occurs with retries exhausted.
- retry_cnt  out  4  timeout retries used in the current bring-up.
- loss_cnt  out  8  saturating count of lock losses seen in RUN or RELEASE.

Behaviour:
- Lock synchronisation:
  - pll_lock passes through a 2-FF synchroniser to give lock_s (2-cycle latency).
  - Both FFs reset to 0.
- Reset values while rst=1:
  - state=PLL_RST, pll_rst=1, dom_rst=all 1s, ready=0, fault=0.
  - retry_cnt=0, loss_cnt=0, all counters=0.
- PLL_RST:
  - pll_rst=1 and dom_rst all 1.
  - After PLL_RST_CYC cycles in state, go to WAIT_LOCK; pll_rst=0 from that edge.
- WAIT_LOCK:
  - stab_cnt increments while lock_s=1 and clears to 0 on any lock_s=0 cycle.
  - tmo_cnt increments every cycle.
  - When stab_cnt reaches LOCK_STABLE, go to RELEASE. This takes priority over a timeout in the same cycle.
  - When tmo_cnt reaches LOCK_TIMEOUT:
    - if retry_cnt<MAX_RETRY: retry_cnt+1 and go to PLL_RST;
    - else go to FAULT.
- RELEASE:
  - rel_cnt starts at 0 on entry.
  - dom_rst[i] deasserts on the edge where rel_cnt==i*STAGGER; dom_rst[0] falls on the entry cycle's next edge.
  - After dom_rst[N_DOM-1] falls: go to RUN, set ready=1, clear retry_cnt.
  - Once released, a bit stays low until teardown.
- RUN:
  - Holds while lock_s=1.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - On the next edge: dom_rst=all 1s, ready=0, loss_cnt+1 (saturates at 255), go to PLL_RST.
  - retry_cnt is not incremented.
- FAULT:
  - pll_rst=1, dom_rst all 1, ready=0, fault=1.
  - Stays in FAULT regardless of pll_lock.
- soft_rst:
  - In any state, on the next edge: go to PLL_RST, clear retry_cnt and fault, dom_rst=all 1s, ready=0.
  - loss_cnt is preserved.
  - soft_rst wins over lock loss and over timeout in the same cycle; lock loss is then not counted.
- Counter sizing: counters are sized with $clog2 of their terminal value + 1 and must never wrap inside a state.
- rst asserted mid-sequence: all outputs return to reset values asynchronously, with no glitch-free requirement on dom_rst.
- Registering: all outputs are registered; no combinational path from pll_lock or soft_rst to any output.

Test Plan:
1. Nominal bring-up, defaults: pll_lock rises at cycle 30 and stays high.
   - pll_rst is high for cycles 0-15.
   - dom_rst[0] falls 1024+2 cycles after lock_s rises; dom_rst[1] falls 8 cycles later.
   - ready=1 on the cycle after that; retry_cnt=0.
2. Lock bounce: lock high 500 cycles, low 1 cycle, then high.
   - stab_cnt restarts; release occurs 1024 cycles after the final rise.
   - loss_cnt stays 0.
3. Timeout/retry, LOCK_TIMEOUT=2000, MAX_RETRY=2, lock never asserts:
   - pll_rst pulses 3 times; retry_cnt steps 0,1,2.
   - fault=1 after the third timeout; dom_rst stays all 1s.
   - Then soft_rst with lock high → clean bring-up, fault=0.
4. Lock loss in RUN, N_DOM=4:
   - drop pll_lock for 1 cycle → all dom_rst high 3 cycles later, ready=0, loss_cnt=1.
   - Resequence gives releases spaced 8 cycles apart, in order 0,1,2,3.
5. Lock loss in RELEASE after dom_rst[0] falls but before dom_rst[1]:
   - all bits reassert, loss_cnt=1.
   - Repeat 256 times → loss_cnt saturates at 255.
6. Simultaneous events:
   - soft_rst on the same cycle as lock_s falls in RUN → PLL_RST, loss_cnt unchanged.
   - rst pulsed mid-RELEASE → all outputs at reset values immediately.
